// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared state, entry types and reset constant for the instruction-fetch front end
package ifu_pkg;

    localparam logic [31:0] IFU_RESET_PC = 32'h0000_3000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DRAIN = 2'd1,
        FAULT = 2'd2
    } ifu_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ifu_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// rtl/ifu_fifo.sv - synchronous DEPTH x 64 prefetch FIFO with flush, count and full/empty
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  ifu_entry_t               push_data,
    input  logic                     pop,
    output ifu_entry_t               head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    ifu_entry_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset && !flush && do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ifu_prefetch.sv
// rtl/ifu_prefetch.sv - fetch PC, imem req/ack FSM and prefetch FIFO; IFU_ALIGN_CHECK_EN enables misaligned-redirect fault
module ifu_prefetch
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IFU_RESET_PC,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    output logic        fetch_fault
);

    localparam int            CW        = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

    ifu_state_e    state;
    logic [31:0]   fetch_pc;
    logic [31:0]   target_pc;
    logic [31:0]   tgt_pc;
    logic          misaligned;
    logic          fault_q;
    ifu_entry_t    head;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

`ifdef IFU_ALIGN_CHECK_EN
    assign tgt_pc     = redirect_pc;
    assign misaligned = (redirect_pc[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (!reset)              fault_q <= 1'b0;
        else if (redirect_valid) fault_q <= misaligned;
    end
`else
    assign tgt_pc     = redirect_pc & 32'hFFFF_FFFC;
    assign misaligned = 1'b0;
    assign fault_q    = 1'b0;
`endif

    assign fetch_fault = fault_q;

    // DRAIN keeps the old request up until the memory finishes it
    assign imem_req  = reset && (((state == FETCH) && (count < CNT_DEPTH)) || (state == DRAIN));
    assign imem_addr = reset ? fetch_pc : RESET_PC;

    assign push = imem_req && imem_ack && (state == FETCH) && !redirect_valid && !full;
    assign pop  = !empty && instr_ready && !redirect_valid;

    assign instr_valid = !empty;
    assign instr       = empty ? 32'd0 : head.instr;
    assign instr_pc    = empty ? 32'd0 : head.pc;

    ifu_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (push),
        .push_data ('{pc: fetch_pc, instr: imem_rdata}),
        .pop       (pop),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= FETCH;
            fetch_pc  <= RESET_PC;
            target_pc <= RESET_PC;
        end else if (redirect_valid) begin
            target_pc <= tgt_pc;
            if (imem_req && !imem_ack) begin
                state <= DRAIN;
            end else begin
                fetch_pc <= tgt_pc;
                state    <= misaligned ? FAULT : FETCH;
            end
        end else begin
            case (state)
                FETCH: if (push) fetch_pc <= fetch_pc + 32'd4;
                DRAIN: if (imem_ack) begin
                    fetch_pc <= target_pc;
                    state    <= fault_q ? FAULT : FETCH;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/ifu_prefetch.md
# ifu_prefetch

Instruction-fetch front end that sits directly upstream of the processor's decode/control stage. It owns the fetch PC and issues word reads to instruction memory over a req/ack handshake. Returned words and their PCs go into a small prefetch FIFO, and decode drains them through a valid/ready interface. Branch and jump redirects from the datapath flush the FIFO and restart fetch at the target; a response that is in flight during a redirect is discarded.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000: fetch address after reset.
- DEPTH, 4: number of FIFO entries; must be a power of two, ≥2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, synchronous and active-low (asserted when 0).
- redirect_valid  in  1  one-cycle redirect request from the datapath.
- redirect_pc  in  32  redirect target address.
- imem_req  out  1  read request to instruction memory.
- imem_addr  out  32  word address of the read; equals the fetch PC.
- imem_ack  in  1  read completes this cycle; imem_rdata is valid.
- imem_rdata  in  32  instruction word.
- instr_valid  out  1  FIFO head is valid.
- instr  out  32  head instruction; 0 when instr_valid=0.
- instr_pc  out  32  head PC; 0 when instr_valid=0.
- instr_ready  in  1  decode consumes the head this cycle.
- fetch_fault  out  1  misaligned redirect target (see Configuration).

## Operation
- FSM states:
  - FETCH: normal fetching.
  - DRAIN: one transaction is outstanding and its data must be discarded.
  - FAULT: only exists with IFU_ALIGN_CHECK_EN.
- In FETCH, imem_req = (count < DEPTH). Once imem_req is raised, it and imem_addr stay stable until imem_ack. Only one transaction is ever outstanding.
- Ack in FETCH:
  - {fetch_pc, imem_rdata} is pushed into the FIFO.
  - fetch_pc advances by 4, wrapping modulo 2^32.
  - imem_req may stay high the next cycle with the new address.
- Pop: instr_valid && instr_ready removes the head. If a push and a pop happen in the same cycle, count is unchanged.
- Redirect (redirect_valid=1) has priority over push and pop in the same cycle:
  - The FIFO is flushed (count=0).
  - fetch_pc is loaded with redirect_pc.
  - Any imem_ack arriving in that same cycle is discarded.
- Redirect while a transaction is pending with no ack this cycle:
  - Go to DRAIN.
  - imem_req and imem_addr hold the old values until ack.
  - The ack is discarded; then return to FETCH and request redirect_pc.
- Redirect while in DRAIN: update fetch_pc and stay in DRAIN. The last redirect wins.
- Reset:
  - FSM in FETCH; fetch_pc = RESET_PC; FIFO empty.
  - Outputs: instr_valid=0, instr=0, instr_pc=0, fetch_fault=0.
  - imem_req is 0 while reset is asserted and imem_addr = RESET_PC.
  - Reset asserted mid-transaction abandons that transaction. The memory is required to drop it as well.

## Timing
- imem_req is combinational from registered state. In the first cycle after reset releases, imem_req=1 and imem_addr=RESET_PC.
- Ack in cycle N gives instr_valid=1 in cycle N+1. With a zero-wait memory, throughput is one instruction per cycle.
- Redirect in cycle N (nothing pending):
  - instr_valid=0 in cycle N+1.
  - imem_addr=redirect_pc in cycle N+1.
- Full (count==DEPTH): imem_req=0. A pop in cycle N gives imem_req=1 in cycle N+1.
- Empty: instr_valid=0. A push in the same cycle becomes visible the next cycle; there is no bypass.

## Configuration
- IFU_ALIGN_CHECK_EN defined:
  - A redirect with redirect_pc[1:0]≠0 flushes the FIFO and enters FAULT.
  - Any pending transaction still completes with req held, and its data is discarded.
  - After that, imem_req=0.
  - fetch_fault=1 from the next cycle until an aligned redirect, which returns to normal fetching.
- Not defined:
  - redirect_pc[1:0] is forced to 00.
  - fetch_fault is tied to 0 and the FAULT state is absent.

## Structure
- Package ifu_pkg holds:
  - the state enum (FETCH, DRAIN, FAULT);
  - the FIFO entry struct {pc[31:0], instr[31:0]};
  - the default RESET_PC constant.
- Sub-module ifu_fifo: a synchronous DEPTH×64 FIFO with push, pop, flush, count, and full/empty. Pointers are log2(DEPTH) bits wide and wrap naturally.
- The FSM and fetch_pc live in the top.

## Test plan
- Reset release, zero-wait memory (ack in the same cycle as req), instr_ready=1:
  - instr_pc sequence 0x3000, 0x3004, 0x3008… with one per cycle from cycle 2.
- instr_ready=0 with ack always 1:
  - Exactly 4 pushes; then imem_req=0 and imem_addr=0x3010.
  - One pop causes one more request.
- Memory with 3-cycle latency, redirect to 0x4000 in the cycle after req to 0x3000:
  - imem_addr stays 0x3000 until ack.
  - That data is discarded; next request is to 0x4000; first instr_pc=0x4000.
- Redirect, push and pop all in the same cycle with the FIFO holding 2 entries:
  - Next cycle, instr_valid=0, count=0 and imem_addr=redirect_pc.
- Reset asserted (reset=0) mid-drain:
  - All outputs return to their reset values and fetch restarts at 0x3000.
- With IFU_ALIGN_CHECK_EN, redirect to 0x4002:
  - fetch_fault=1 and imem_req=0.
  - A later redirect to 0x5000 clears the fault and fetches 0x5000.
